// File: rtl/omsp_spm_violation_handler_pkg.sv
// Shared types and constants for the SPM violation handler: FSM encoding,
// counter widths and the saturating event-count helper.
package omsp_spm_violation_handler_pkg;

  typedef enum logic [1:0] {
    VH_IDLE  = 2'd0,
    VH_DRAIN = 2'd1,
    VH_RESET = 2'd2,
    VH_IRQ   = 2'd3
  } vh_state_e;

  localparam int VH_CNT_W   = 4;
  localparam int VH_COUNT_W = 8;
  localparam int VH_ID_W    = 16;

  localparam logic [VH_COUNT_W-1:0] VH_COUNT_SAT = 8'hFF;

  // Event count increment that sticks at the saturation value.
  function automatic logic [VH_COUNT_W-1:0] vh_sat_inc(input logic [VH_COUNT_W-1:0] value);
    if (value == VH_COUNT_SAT) begin
      return VH_COUNT_SAT;
    end else begin
      return value + 8'd1;
    end
  endfunction

endpackage

// File: rtl/omsp_spm_violation_handler.sv
// Turns the SPM violation level into a halt, a timed reset request or a
// one-cycle IRQ, and keeps sticky status, captured IDs and an event count.
module omsp_spm_violation_handler
  import omsp_spm_violation_handler_pkg::*;
#(
  parameter int RESET_ON_VIOLATION = 1,
  parameter int HOLD_CYCLES        = 4,
  parameter int DRAIN_MAX          = 8
) (
  input  logic                  mclk,
  input  logic                  puc_rst_n,
  input  logic                  violation,
  input  logic [VH_ID_W-1:0]    spm_current_id,
  input  logic [VH_ID_W-1:0]    spm_prev_id,
  input  logic                  inst_done,
  input  logic                  status_clr,
  output logic                  halt_exec,
  output logic                  viol_reset_req,
  output logic                  viol_irq,
  output logic                  viol_pending,
  output logic                  viol_overrun,
  output logic [VH_ID_W-1:0]    viol_id,
  output logic [VH_ID_W-1:0]    viol_prev_id,
  output logic [VH_COUNT_W-1:0] viol_count
);

  localparam bit                    RESET_MODE = (RESET_ON_VIOLATION != 0);
  localparam logic [VH_CNT_W-1:0]   DRAIN_LD   = VH_CNT_W'(DRAIN_MAX);
  localparam logic [VH_CNT_W-1:0]   HOLD_LD    = VH_CNT_W'(HOLD_CYCLES);

  vh_state_e             state_r;
  vh_state_e             state_s;
  logic                  viol_q_r;
  logic                  viol_evt_s;
  logic [VH_CNT_W-1:0]   vh_cnt_r;
  logic [VH_CNT_W-1:0]   vh_cnt_s;
  logic                  halt_s;
  logic                  reset_req_s;
  logic                  irq_s;
  logic                  pending_s;
  logic                  overrun_s;
  logic [VH_ID_W-1:0]    id_s;
  logic [VH_ID_W-1:0]    prev_id_s;
  logic [VH_COUNT_W-1:0] count_s;

  assign viol_evt_s = violation & ~viol_q_r;

  // FSM state and shared drain/hold down-counter registers.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      state_r  <= VH_IDLE;
      vh_cnt_r <= 4'd0;
      viol_q_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      vh_cnt_r <= vh_cnt_s;
      viol_q_r <= violation;
    end
  end

  // Next state, counter and the next value of the control outputs.
  always_comb begin
    state_s     = state_r;
    vh_cnt_s    = vh_cnt_r;
    halt_s      = 1'b0;
    reset_req_s = 1'b0;
    irq_s       = 1'b0;
    case (state_r)
      VH_IDLE: begin
        if (viol_evt_s) begin
          state_s  = VH_DRAIN;
          vh_cnt_s = DRAIN_LD;
          halt_s   = 1'b1;
        end else begin
          vh_cnt_s = 4'd0;
        end
      end
      VH_DRAIN: begin
        // A counter value of 1 is the last drain cycle before the forced exit.
        if (inst_done || (vh_cnt_r <= 4'd1)) begin
          if (RESET_MODE) begin
            state_s     = VH_RESET;
            vh_cnt_s    = HOLD_LD;
            halt_s      = 1'b1;
            reset_req_s = 1'b1;
          end else begin
            state_s  = VH_IRQ;
            vh_cnt_s = 4'd0;
            irq_s    = 1'b1;
          end
        end else begin
          vh_cnt_s = vh_cnt_r - 4'd1;
          halt_s   = 1'b1;
        end
      end
      VH_RESET: begin
        if (vh_cnt_r <= 4'd1) begin
          state_s  = VH_IDLE;
          vh_cnt_s = 4'd0;
        end else begin
          vh_cnt_s    = vh_cnt_r - 4'd1;
          halt_s      = 1'b1;
          reset_req_s = 1'b1;
        end
      end
      VH_IRQ: begin
        state_s  = VH_IDLE;
        vh_cnt_s = 4'd0;
      end
      default: begin
        state_s  = VH_IDLE;
        vh_cnt_s = 4'd0;
      end
    endcase
  end

  // Status update: a coincident clear is applied before the event.
  always_comb begin
    pending_s = viol_pending;
    overrun_s = viol_overrun;
    id_s      = viol_id;
    prev_id_s = viol_prev_id;
    count_s   = viol_count;
    if (status_clr) begin
      pending_s = 1'b0;
      overrun_s = 1'b0;
      id_s      = 16'h0000;
      prev_id_s = 16'h0000;
      count_s   = 8'h00;
    end else begin
      pending_s = viol_pending;
    end
    if (viol_evt_s) begin
      count_s = vh_sat_inc(count_s);
      if (state_r == VH_IDLE) begin
        if (!pending_s) begin
          id_s      = spm_current_id;
          prev_id_s = spm_prev_id;
        end else begin
          id_s = id_s;
        end
        pending_s = 1'b1;
      end else begin
        overrun_s = 1'b1;
      end
    end else begin
      count_s = count_s;
    end
  end

  // Registered outputs.
  always_ff @(posedge mclk or negedge puc_rst_n) begin
    if (!puc_rst_n) begin
      halt_exec      <= 1'b0;
      viol_reset_req <= 1'b0;
      viol_irq       <= 1'b0;
      viol_pending   <= 1'b0;
      viol_overrun   <= 1'b0;
      viol_id        <= 16'h0000;
      viol_prev_id   <= 16'h0000;
      viol_count     <= 8'h00;
    end else begin
      halt_exec      <= halt_s;
      viol_reset_req <= reset_req_s;
      viol_irq       <= irq_s;
      viol_pending   <= pending_s;
      viol_overrun   <= overrun_s;
      viol_id        <= id_s;
      viol_prev_id   <= prev_id_s;
      viol_count     <= count_s;
    end
  end

endmodule

// File: tb/tb_omsp_spm_violation_handler.sv
// Directed bench: dut_a runs in reset-request mode, dut_b in IRQ mode,
// both on shared stimulus; each scenario checks its own DUT's outputs.
module tb_omsp_spm_violation_handler;

  logic        mclk;
  logic        puc_rst_n;
  logic        violation;
  logic [15:0] spm_current_id;
  logic [15:0] spm_prev_id;
  logic        inst_done;
  logic        status_clr;

  logic        halt_a, req_a, irq_a, pend_a, ovr_a;
  logic [15:0] id_a, prev_a;
  logic [7:0]  cnt_a;
  logic        halt_b, req_b, irq_b, pend_b, ovr_b;
  logic [15:0] id_b, prev_b;
  logic [7:0]  cnt_b;

  int errors = 0;
  int checks = 0;

  omsp_spm_violation_handler #(
    .RESET_ON_VIOLATION(1), .HOLD_CYCLES(4), .DRAIN_MAX(8)
  ) dut_a (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .violation(violation),
    .spm_current_id(spm_current_id), .spm_prev_id(spm_prev_id),
    .inst_done(inst_done), .status_clr(status_clr),
    .halt_exec(halt_a), .viol_reset_req(req_a), .viol_irq(irq_a),
    .viol_pending(pend_a), .viol_overrun(ovr_a), .viol_id(id_a),
    .viol_prev_id(prev_a), .viol_count(cnt_a)
  );

  omsp_spm_violation_handler #(
    .RESET_ON_VIOLATION(0), .HOLD_CYCLES(4), .DRAIN_MAX(8)
  ) dut_b (
    .mclk(mclk), .puc_rst_n(puc_rst_n), .violation(violation),
    .spm_current_id(spm_current_id), .spm_prev_id(spm_prev_id),
    .inst_done(inst_done), .status_clr(status_clr),
    .halt_exec(halt_b), .viol_reset_req(req_b), .viol_irq(irq_b),
    .viol_pending(pend_b), .viol_overrun(ovr_b), .viol_id(id_b),
    .viol_prev_id(prev_b), .viol_count(cnt_b)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic apply_reset();
    puc_rst_n      = 1'b0;
    violation      = 1'b0;
    spm_current_id = 16'h0000;
    spm_prev_id    = 16'h0000;
    inst_done      = 1'b0;
    status_clr     = 1'b0;
    step();
    step();
    puc_rst_n = 1'b1;
    step();
  endtask

  // One IRQ-mode event with fast drain: three cycles, ends in IDLE.
  task automatic irq_event(input logic [15:0] cur, input logic [15:0] prv);
    violation      = 1'b1;
    spm_current_id = cur;
    spm_prev_id    = prv;
    step();
    violation = 1'b0;
    inst_done = 1'b1;
    step();
    inst_done = 1'b0;
    step();
  endtask

  task automatic test_reset();
    logic [69:0] obs;
    puc_rst_n = 1'b0;
    violation = 1'b0; inst_done = 1'b0; status_clr = 1'b0;
    spm_current_id = 16'h0000; spm_prev_id = 16'h0000;
    step();
    obs = {halt_a, req_a, irq_a, pend_a, ovr_a, id_a, prev_a, cnt_a,
           halt_b, req_b, irq_b};
    checks++;
    if (obs !== 70'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", obs);
    end
    puc_rst_n = 1'b1;
    step();
    step();
    obs = {halt_a, req_a, irq_a, pend_a, ovr_a, id_a, prev_a, cnt_a,
           halt_b, req_b, irq_b};
    checks++;
    if (obs !== 70'd0) begin
      errors++;
      $display("FAIL idle_after_reset: got %h expected 0", obs);
    end
  endtask

  task automatic test_reset_mode();
    int drain_c = 0;
    int req_c = 0;
    apply_reset();
    violation = 1'b1; spm_current_id = 16'h0003; spm_prev_id = 16'h0001;
    step();
    violation = 1'b0;
    checks++;
    if ({halt_a, pend_a, req_a} !== 3'b110) begin
      errors++;
      $display("FAIL capture_flags: got halt/pend/req=%b expected 110", {halt_a, pend_a, req_a});
    end
    checks++;
    if ({id_a, prev_a, cnt_a} !== {16'h0003, 16'h0001, 8'h01}) begin
      errors++;
      $display("FAIL capture_ids: got id=%h prev=%h cnt=%h expected 0003 0001 01", id_a, prev_a, cnt_a);
    end
    for (int i = 0; i < 40; i++) begin
      if (!halt_a) break;
      if (!req_a) drain_c++;
      else req_c++;
      step();
    end
    checks++;
    if (drain_c !== 8) begin
      errors++;
      $display("FAIL drain_len: got %0d expected 8", drain_c);
    end
    checks++;
    if (req_c !== 4) begin
      errors++;
      $display("FAIL hold_len: got %0d expected 4", req_c);
    end
    checks++;
    if ({halt_a, req_a, irq_a, pend_a} !== 4'b0001) begin
      errors++;
      $display("FAIL back_idle_a: got %b expected 0001", {halt_a, req_a, irq_a, pend_a});
    end
  endtask

  task automatic test_irq_mode();
    apply_reset();
    violation = 1'b1; spm_current_id = 16'h0007; spm_prev_id = 16'h0006;
    step();
    violation = 1'b0;
    inst_done = 1'b1;
    checks++;
    if ({halt_b, irq_b} !== 2'b10) begin
      errors++;
      $display("FAIL irq_drain: got halt/irq=%b expected 10", {halt_b, irq_b});
    end
    step();
    inst_done = 1'b0;
    checks++;
    if ({halt_b, irq_b, req_b} !== 3'b010) begin
      errors++;
      $display("FAIL irq_pulse: got halt/irq/req=%b expected 010", {halt_b, irq_b, req_b});
    end
    step();
    checks++;
    if ({halt_b, irq_b} !== 2'b00) begin
      errors++;
      $display("FAIL irq_single: got halt/irq=%b expected 00", {halt_b, irq_b});
    end
    violation = 1'b1;
    step();
    violation = 1'b0;
    checks++;
    if ({halt_b, cnt_b, id_b} !== {1'b1, 8'h02, 16'h0007}) begin
      errors++;
      $display("FAIL irq_reentry: got halt=%b cnt=%h id=%h expected 1 02 0007", halt_b, cnt_b, id_b);
    end
  endtask

  task automatic test_overrun();
    int req_c = 0;
    apply_reset();
    violation = 1'b1; spm_current_id = 16'h0003; spm_prev_id = 16'h0001;
    step();
    violation = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (req_a) break;
      step();
    end
    checks++;
    if (req_a !== 1'b1) begin
      errors++;
      $display("FAIL ovr_wait_req: got %b expected 1", req_a);
    end
    req_c = 1;
    violation = 1'b1; spm_current_id = 16'h0005; spm_prev_id = 16'h0004;
    step();
    violation = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!req_a) break;
      req_c++;
      step();
    end
    checks++;
    if (req_c !== 4) begin
      errors++;
      $display("FAIL ovr_hold_len: got %0d expected 4", req_c);
    end
    checks++;
    if ({cnt_a, ovr_a, id_a, prev_a} !== {8'h02, 1'b1, 16'h0003, 16'h0001}) begin
      errors++;
      $display("FAIL ovr_status: got cnt=%h ovr=%b id=%h prev=%h expected 02 1 0003 0001",
               cnt_a, ovr_a, id_a, prev_a);
    end
  endtask

  task automatic test_clear_and_event();
    apply_reset();
    for (int i = 0; i < 7; i++) irq_event(16'h0003, 16'h0002);
    checks++;
    if ({cnt_b, id_b} !== {8'h07, 16'h0003}) begin
      errors++;
      $display("FAIL clr_pre: got cnt=%h id=%h expected 07 0003", cnt_b, id_b);
    end
    status_clr = 1'b1;
    violation = 1'b1; spm_current_id = 16'h0009; spm_prev_id = 16'h0008;
    step();
    status_clr = 1'b0;
    violation = 1'b0;
    checks++;
    if ({cnt_b, pend_b, ovr_b, id_b, prev_b} !== {8'h01, 1'b1, 1'b0, 16'h0009, 16'h0008}) begin
      errors++;
      $display("FAIL clr_event: got cnt=%h pend=%b ovr=%b id=%h prev=%h expected 01 1 0 0009 0008",
               cnt_b, pend_b, ovr_b, id_b, prev_b);
    end
  endtask

  task automatic test_saturation_and_level();
    int irq_c = 0;
    apply_reset();
    for (int i = 0; i < 300; i++) irq_event(16'h0011, 16'h0010);
    checks++;
    if (cnt_b !== 8'hFF) begin
      errors++;
      $display("FAIL saturate: got %h expected ff", cnt_b);
    end
    status_clr = 1'b1;
    step();
    status_clr = 1'b0;
    checks++;
    if ({cnt_b, pend_b} !== {8'h00, 1'b0}) begin
      errors++;
      $display("FAIL status_clr: got cnt=%h pend=%b expected 00 0", cnt_b, pend_b);
    end
    violation = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (irq_b) irq_c++;
    end
    violation = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (irq_b) irq_c++;
    end
    checks++;
    if ({cnt_b, ovr_b} !== {8'h01, 1'b0}) begin
      errors++;
      $display("FAIL level_hold: got cnt=%h ovr=%b expected 01 0", cnt_b, ovr_b);
    end
    checks++;
    if (irq_c !== 1) begin
      errors++;
      $display("FAIL level_irqs: got %0d expected 1", irq_c);
    end
  endtask

  task automatic test_reset_mid_sequence();
    logic seen;
    logic [69:0] obs;
    apply_reset();
    violation = 1'b1; spm_current_id = 16'h0003; spm_prev_id = 16'h0001;
    step();
    violation = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (req_a) break;
      step();
    end
    step();
    checks++;
    if (req_a !== 1'b1) begin
      errors++;
      $display("FAIL mid_req_cycle2: got %b expected 1", req_a);
    end
    puc_rst_n = 1'b0;
    #1;
    obs = {halt_a, req_a, irq_a, pend_a, ovr_a, id_a, prev_a, cnt_a,
           halt_b, req_b, irq_b};
    checks++;
    if (obs !== 70'd0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %h expected 0", obs);
    end
    #1;
    puc_rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (req_a || halt_a || irq_a) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_residual: got %b expected 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mode();
    test_irq_mode();
    test_overrun();
    test_clear_and_event();
    test_saturation_and_level();
    test_reset_mid_sequence();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
